// File: rtl/pristis_sync_sequencer_if.sv
// Measurement-counter and result-bank bus for the sync sequencer.
// The master side is the sequencer; the slave side is the counter and bank.
interface pristis_sync_sequencer_if #(
   parameter int CNT_WIDTH = 16
);
   logic [1:0]           meas_sel;
   logic                 meas_start;
   logic                 meas_done;
   logic [CNT_WIDTH-1:0] meas_count;
   logic                 result_wr;
   logic [1:0]           result_idx;
   logic [CNT_WIDTH-1:0] result_data;

   modport master (
      output meas_sel, meas_start,
      output result_wr, result_idx, result_data,
      input  meas_done, meas_count
   );

   modport slave (
      input  meas_sel, meas_start,
      input  result_wr, result_idx, result_data,
      output meas_done, meas_count
   );
endinterface

// File: rtl/pristis_sync_sequencer.sv
// Steps through enabled channel pairs, measures each and checks sync.
// Optional WAIT timeout is built only when PRISTIS_SEQ_TIMEOUT_EN is defined.
module pristis_sync_sequencer #(
   parameter int NUM_PAIRS      = 4,
   parameter int CNT_WIDTH      = 16,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           pair_mask,
   input  logic [CNT_WIDTH-1:0] tolerance,
   output logic                 busy,
   output logic                 done,
   output logic                 in_sync,
   output logic                 err_timeout,
   pristis_sync_sequencer_if.master bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SELECT = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_TRIG   = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_STORE  = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;

   localparam logic [1:0] LAST_IDX    = 2'(NUM_PAIRS - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1)
   begin : g_bad_cfg
      $error("pristis_sync_sequencer: parameter out of range");
   end

   logic [2:0]           state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [1:0]           sel_q, sel_d;
   logic [7:0]           set_q, set_d;
   logic [3:0]           mask_q, mask_d;
   logic [CNT_WIDTH-1:0] tol_q, tol_d;
   logic [CNT_WIDTH-1:0] data_q, data_d;
   logic                 ok_q, ok_d;
   logic                 sync_q, sync_d;
   logic                 nxt_found;
   logic [1:0]           nxt_idx;
   logic                 pair_ok;

`ifdef PRISTIS_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   logic          tmo_hit;
   assign tmo_hit = (tmo_q == TMO_LAST);
`endif

   // Descending scan so the lowest enabled index at or above idx_q wins
   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = idx_q;
      for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
         if (mask_q[i] && (2'(i) >= idx_q)) begin
            nxt_found = 1'b1;
            nxt_idx   = 2'(i);
         end
      end
   end

   assign pair_ok = ok_q & (data_q <= tol_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      set_d   = set_q;
      mask_d  = mask_q;
      tol_d   = tol_q;
      data_d  = data_q;
      ok_d    = ok_q;
      sync_d  = sync_q;
`ifdef PRISTIS_SEQ_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d  = pair_mask;
               tol_d   = tolerance;
               idx_d   = 2'd0;
               ok_d    = 1'b1;
`ifdef PRISTIS_SEQ_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            if (!nxt_found) begin
               sync_d  = ok_q;
               state_d = S_FINISH;
            end else begin
               idx_d   = nxt_idx;
               sel_d   = nxt_idx;
               set_d   = 8'd0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (set_q == SETTLE_LAST) state_d = S_TRIG;
            else                      set_d   = set_q + 8'd1;
         end
         S_TRIG: begin
`ifdef PRISTIS_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.meas_done) begin
               data_d  = bus.meas_count;
               state_d = S_STORE;
            end
`ifdef PRISTIS_SEQ_TIMEOUT_EN
            else if (tmo_hit) begin
               ok_d    = 1'b0;
               sync_d  = 1'b0;
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else begin
               tmo_d   = tmo_q + 1'b1;
            end
`endif
         end
         S_STORE: begin
            ok_d = pair_ok;
            if (idx_q == LAST_IDX) begin
               sync_d  = pair_ok;
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_SELECT;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         sel_q   <= '0;
         set_q   <= '0;
         mask_q  <= '0;
         tol_q   <= '0;
         data_q  <= '0;
         ok_q    <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         set_q   <= set_d;
         mask_q  <= mask_d;
         tol_q   <= tol_d;
         data_q  <= data_d;
         ok_q    <= ok_d;
         sync_q  <= sync_d;
      end
   end

`ifdef PRISTIS_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign done            = (state_q == S_FINISH);
   assign in_sync         = sync_q;
   assign bus.meas_sel    = sel_q;
   assign bus.meas_start  = (state_q == S_TRIG);
   assign bus.result_wr   = (state_q == S_STORE);
   assign bus.result_idx  = idx_q;
   assign bus.result_data = data_q;

endmodule

// File: tb/tb_pristis_sync_sequencer.sv
// Self-checking bench for pristis_sync_sequencer: vector table, hand
// sequences and randomized runs against a pair-list reference model.
module tb_pristis_sync_sequencer;
   localparam int CW = 16;
   localparam int S  = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    pair_mask;
   logic [CW-1:0] tolerance;
   logic          busy, done, in_sync, err_timeout;

   pristis_sync_sequencer_if #(.CNT_WIDTH(CW)) bus ();

   pristis_sync_sequencer #(
      .NUM_PAIRS(4), .CNT_WIDTH(CW),
      .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .pair_mask(pair_mask), .tolerance(tolerance),
      .busy(busy), .done(done), .in_sync(in_sync),
      .err_timeout(err_timeout), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Measurement counter model
   logic [3:0][CW-1:0] r_cnt;
   int                 r_dly [4];
   bit                 r_en = 1'b1;

   initial begin
      bus.meas_done  = 1'b0;
      bus.meas_count = '0;
      forever begin
         @(posedge clk);
         #1;
         if (r_en && !rst && bus.meas_start) begin
            int s;
            s = int'(bus.meas_sel);
            @(posedge clk);
            repeat (r_dly[s]) @(posedge clk);
            #1 bus.meas_done = 1'b1;
            bus.meas_count = r_cnt[s];
            @(posedge clk);
            #1 bus.meas_done = 1'b0;
         end
      end
   end

   // Output monitor
   typedef struct packed {
      logic [1:0]    idx;
      logic [CW-1:0] data;
   } wr_t;

   wr_t        wq[$];
   int         n_done, done_cyc, n_mstart;
   logic [3:0] sel_seen;
   logic       sync_at_done, err_at_done;

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            n_done++;
            done_cyc     = cyc;
            sync_at_done = in_sync;
            err_at_done  = err_timeout;
         end
         if (bus.meas_start) begin
            n_mstart++;
            sel_seen[bus.meas_sel] = 1'b1;
         end
         if (bus.result_wr) wq.push_back({bus.result_idx, bus.result_data});
      end
   end

   task automatic clear_mon();
      wq.delete();
      n_done       = 0;
      done_cyc     = -1;
      n_mstart     = 0;
      sel_seen     = 4'h0;
      sync_at_done = 1'bx;
      err_at_done  = 1'bx;
   endtask

   task automatic pulse_start(input logic [3:0] m, input logic [CW-1:0] tol);
      pair_mask = m;
      tolerance = tol;
      start     = 1'b1;
      @(posedge clk);
      #1 start  = 1'b0;
      pair_mask = 4'($urandom);
      tolerance = CW'($urandom);
   endtask

   task automatic wait_done(input string nm);
      int w = 0;
      while (n_done == 0 && w < 3000) begin
         @(posedge clk);
         w++;
      end
      if (n_done == 0) chk({nm, "_done_seen"}, 0, 1);
   endtask

   // Reference: ordered list of enabled pairs, sync = all counts within tol
   task automatic run_seq(input string nm, input logic [3:0] m,
                          input logic [CW-1:0] tol, input bit poke,
                          output logic got_sync, output int got_nwr);
      wr_t exp_q[$];
      logic exp_sync = 1'b1;
      int   span = 0;
      int   t0;
      clear_mon();
      t0 = cyc;
      pulse_start(m, tol);
      fork
         wait_done(nm);
         if (poke) begin
            repeat (3) @(posedge clk);
            #1 bus.meas_done = 1'b1;
            bus.meas_count = CW'(16'hBEEF);
            @(posedge clk);
            #1 bus.meas_done = 1'b0;
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            pair_mask = 4'hF;
            @(posedge clk);
            #1 start = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            exp_q.push_back({2'(i), r_cnt[i]});
            if (r_cnt[i] > tol) exp_sync = 1'b0;
            span += S + 3 + r_dly[i] + 1;
         end
      end
      chk({nm, "_done_count"}, n_done, 1);
      chk({nm, "_done_cycle"}, done_cyc, t0 + 1 + span + (m[3] ? 0 : 1));
      chk({nm, "_in_sync"}, int'(sync_at_done), int'(exp_sync));
      chk({nm, "_err_timeout"}, int'(err_at_done), 0);
      chk({nm, "_meas_starts"}, n_mstart, $countones(m));
      chk({nm, "_sel_seen"}, int'(sel_seen), int'(m));
      chk({nm, "_wr_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         chk({nm, "_wr_idx"}, int'(wq[i].idx), int'(exp_q[i].idx));
         chk({nm, "_wr_data"}, int'(wq[i].data), int'(exp_q[i].data));
      end
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_in_sync_hold"}, int'(in_sync), int'(exp_sync));
      got_sync = sync_at_done;
      got_nwr  = wq.size();
   endtask

   typedef struct {
      string              nm;
      logic [3:0]         m;
      logic [CW-1:0]      tol;
      logic [3:0][CW-1:0] c;
      int                 d0, d1, d2, d3;
      logic               es;
      int                 nwr;
   } vec_t;

   vec_t tv [6];

   initial begin
      logic gs;
      int   gn;

      tv[0] = '{"all_in",   4'hF,    16'd10,   {16'd5, 16'd5, 16'd5, 16'd5},
                0, 1, 2, 3, 1'b1, 4};
      tv[1] = '{"mask0101", 4'b0101, 16'd10,   {16'd50, 16'd11, 16'd50, 16'd5},
                1, 0, 2, 0, 1'b0, 2};
      tv[2] = '{"mask0",    4'h0,    16'd10,   {16'd1, 16'd1, 16'd1, 16'd1},
                0, 0, 0, 0, 1'b1, 0};
      tv[3] = '{"eq_tol",   4'b1000, 16'd7,    {16'd7, 16'd0, 16'd0, 16'd0},
                0, 0, 0, 2, 1'b1, 1};
      tv[4] = '{"tol_p1",   4'b0010, 16'd0,    {16'd0, 16'd0, 16'd1, 16'd0},
                0, 4, 0, 0, 1'b0, 1};
      tv[5] = '{"max_cnt",  4'b1001, 16'hFFFF, {16'hFFFF, 16'd0, 16'd0, 16'hFFFF},
                3, 0, 0, 0, 1'b1, 2};

      rst = 1'b1;
      start = 1'b0;
      pair_mask = 4'h0;
      tolerance = '0;
      r_cnt = '0;
      for (int i = 0; i < 4; i++) r_dly[i] = 0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_in_sync", int'(in_sync), 0);
      chk("rst_err", int'(err_timeout), 0);
      chk("rst_meas_start", int'(bus.meas_start), 0);
      chk("rst_result_wr", int'(bus.result_wr), 0);
      chk("rst_meas_sel", int'(bus.meas_sel), 0);
      rst = 1'b0;

      foreach (tv[k]) begin
         r_cnt = tv[k].c;
         r_dly[0] = tv[k].d0;
         r_dly[1] = tv[k].d1;
         r_dly[2] = tv[k].d2;
         r_dly[3] = tv[k].d3;
         run_seq(tv[k].nm, tv[k].m, tv[k].tol, 1'b0, gs, gn);
         chk({tv[k].nm, "_tbl_sync"}, int'(gs), int'(tv[k].es));
         chk({tv[k].nm, "_tbl_nwr"}, gn, tv[k].nwr);
      end

      // Stray meas_done in SETTLE and start during WAIT must be ignored
      r_cnt = {16'd0, 16'd0, 16'd4, 16'd2};
      r_dly[0] = 5;
      r_dly[1] = 0;
      run_seq("poke", 4'b0011, 16'd3, 1'b1, gs, gn);
      chk("poke_sync", int'(gs), 0);

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] = CW'($urandom_range(0, 25));
            r_dly[i] = int'($urandom_range(0, 6));
         end
         run_seq("rand", 4'($urandom_range(0, 15)),
                 CW'($urandom_range(0, 20)), 1'b0, gs, gn);
      end

      // Abort during SETTLE of pair 1
      r_cnt = {16'd3, 16'd3, 16'd3, 16'd3};
      for (int i = 0; i < 4; i++) r_dly[i] = 0;
      run_seq("pre_abort", 4'hF, 16'd10, 1'b0, gs, gn);
      clear_mon();
      pulse_start(4'hF, 16'd10);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_pre_busy", int'(busy), 1);
      chk("abort_pre_sel", int'(bus.meas_sel), 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_in_sync", int'(in_sync), 0);
      chk("abort_err", int'(err_timeout), 0);
      chk("abort_meas_start", int'(bus.meas_start), 0);
      chk("abort_result_wr", int'(bus.result_wr), 0);
      chk("abort_meas_sel", int'(bus.meas_sel), 0);
      chk("abort_result_idx", int'(bus.result_idx), 0);
      chk("abort_result_data", int'(bus.result_data), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", n_done, 0);
      rst = 1'b0;
      run_seq("post_abort", 4'hF, 16'd2, 1'b0, gs, gn);

`ifdef PRISTIS_SEQ_TIMEOUT_EN
      begin
         int t0;
         r_en = 1'b0;
         clear_mon();
         t0 = cyc;
         pulse_start(4'b0001, 16'd10);
         wait_done("tmo");
         repeat (2) @(posedge clk);
         #1;
         chk("tmo_done_count", n_done, 1);
         chk("tmo_done_cycle", done_cyc, t0 + 1 + (S + 2) + TO);
         chk("tmo_err_at_done", int'(err_at_done), 1);
         chk("tmo_sync_at_done", int'(sync_at_done), 0);
         chk("tmo_wr_count", wq.size(), 0);
         chk("tmo_err_sticky", int'(err_timeout), 1);
         chk("tmo_busy_after", int'(busy), 0);
         r_en = 1'b1;
         r_cnt = {16'd1, 16'd1, 16'd1, 16'd1};
         run_seq("tmo_next", 4'b0001, 16'd10, 1'b0, gs, gn);
         chk("tmo_err_cleared", int'(err_timeout), 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
